// File: rtl/tap_pkg.sv
// Shared TAP definitions: the 16 controller states, instruction codes and the IR capture pattern.
package tap_pkg;

   localparam int IR_W = 4;

   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_state_e;

   localparam logic [IR_W-1:0] INSTR_IDC  = 4'h1;
   localparam logic [IR_W-1:0] INSTR_CSEL = 4'h8;
   localparam logic [IR_W-1:0] INSTR_BYP  = 4'hF;
   localparam logic [IR_W-1:0] CAPIR_VAL  = 4'b0101;

endpackage

// File: rtl/tap_fsm.sv
// TMS-driven TAP state machine; exposes both the current and the next state.
module tap_fsm
   import tap_pkg::*;
(
   input  logic       tck_i,
   input  logic       trst_ni,
   input  logic       tms_i,
   output tap_state_e state_o,
   output tap_state_e state_d_o
);

   tap_state_e state_q, state_d;

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) state_q <= TLR;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:    state_d = tms_i ? TLR    : RTI;
         RTI:    state_d = tms_i ? SEL_DR : RTI;
         SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms_i ? UPD_DR : PAU_DR;
         PAU_DR: state_d = tms_i ? EX2_DR : PAU_DR;
         EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms_i ? SEL_DR : RTI;
         SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
         CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms_i ? UPD_IR : PAU_IR;
         PAU_IR: state_d = tms_i ? EX2_IR : PAU_IR;
         EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms_i ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   assign state_o   = state_q;
   assign state_d_o = state_d;

endmodule

// File: rtl/tap_ctrl_clksel.sv
// JTAG TAP with IDCODE/BYPASS/CLKSEL data registers; CLKSEL drives the clock mux select
// (1 = chip clock, 0 = TCK). Everything runs on TCK; TDO is retimed on the falling edge.
module tap_ctrl_clksel
   import tap_pkg::*;
#(
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
   input  logic tck_i,
   input  logic trst_ni,
   input  logic tms_i,
   input  logic tdi_i,
   output logic tdo_o,
   output logic tdo_en_o,
   output logic clksel_o,
   output logic tap_rst_o
);

   tap_state_e state, state_nxt;

   logic [IR_W-1:0] ir_q, ir_d, ir_sh_q, ir_sh_d;
   logic [31:0]     idc_sh_q, idc_sh_d;
   logic            byp_q, byp_d, csel_sh_q, csel_sh_d, clksel_q, clksel_d;
   logic            tdo_q, tdo_d, tdo_en_q, tdo_en_d;
   logic            sel_idc, sel_csel;

   tap_fsm u_fsm (
      .tck_i     (tck_i),
      .trst_ni   (trst_ni),
      .tms_i     (tms_i),
      .state_o   (state),
      .state_d_o (state_nxt)
   );

   assign sel_idc  = (ir_q == INSTR_IDC);
   assign sel_csel = (ir_q == INSTR_CSEL);

   always_comb begin
      ir_d      = ir_q;
      ir_sh_d   = ir_sh_q;
      idc_sh_d  = idc_sh_q;
      byp_d     = byp_q;
      csel_sh_d = csel_sh_q;
      clksel_d  = clksel_q;
      unique case (state)
         CAP_IR: ir_sh_d = CAPIR_VAL;
         SH_IR:  ir_sh_d = {tdi_i, ir_sh_q[IR_W-1:1]};
         UPD_IR: ir_d    = ir_sh_q;
         CAP_DR: begin
            if (sel_idc)       idc_sh_d  = IDCODE_VAL;
            else if (sel_csel) csel_sh_d = clksel_q;
            else               byp_d     = 1'b0;
         end
         SH_DR: begin
            if (sel_idc)       idc_sh_d  = {tdi_i, idc_sh_q[31:1]};
            else if (sel_csel) csel_sh_d = tdi_i;
            else               byp_d     = tdi_i;
         end
         UPD_DR: if (sel_csel) clksel_d = csel_sh_q;
         default: ;
      endcase
      // Entering Test-Logic-Reset via TMS restores the safe defaults on that same edge.
      if (state_nxt == TLR) begin
         ir_d     = INSTR_IDC;
         clksel_d = 1'b1;
      end
   end

   always_comb begin
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
      if (state == SH_IR) begin
         tdo_d    = ir_sh_q[0];
         tdo_en_d = 1'b1;
      end else if (state == SH_DR) begin
         tdo_en_d = 1'b1;
         if (sel_idc)       tdo_d = idc_sh_q[0];
         else if (sel_csel) tdo_d = csel_sh_q;
         else               tdo_d = byp_q;
      end
   end

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         ir_q      <= INSTR_IDC;
         ir_sh_q   <= '0;
         idc_sh_q  <= '0;
         byp_q     <= 1'b0;
         csel_sh_q <= 1'b0;
         clksel_q  <= 1'b1;
      end else begin
         ir_q      <= ir_d;
         ir_sh_q   <= ir_sh_d;
         idc_sh_q  <= idc_sh_d;
         byp_q     <= byp_d;
         csel_sh_q <= csel_sh_d;
         clksel_q  <= clksel_d;
      end
   end

   always_ff @(negedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   assign tdo_o     = tdo_q;
   assign tdo_en_o  = tdo_en_q;
   assign clksel_o  = clksel_q;
   assign tap_rst_o = (state == TLR);

endmodule

// File: tb/tb_tap_ctrl_clksel.sv
// Directed bench for tap_ctrl_clksel: state walk, IR/DR scans, CLKSEL commit and async reset.
module tb_tap_ctrl_clksel;
   import tap_pkg::*;

   logic tck_i = 1'b0, trst_ni = 1'b0, tms_i = 1'b1, tdi_i = 1'b0;
   logic tdo_o, tdo_en_o, clksel_o, tap_rst_o;
   int   tests = 0, fails = 0;

   tap_ctrl_clksel dut (
      .tck_i(tck_i), .trst_ni(trst_ni), .tms_i(tms_i), .tdi_i(tdi_i),
      .tdo_o(tdo_o), .tdo_en_o(tdo_en_o), .clksel_o(clksel_o), .tap_rst_o(tap_rst_o)
   );

   always #5 tck_i = ~tck_i;

   // Drive one TCK cycle; tdo/en are sampled just before the rising edge that consumes them.
   task automatic tick(input logic tms, input logic tdi, output logic tdo, output logic en);
      tms_i = tms;
      tdi_i = tdi;
      tdo   = tdo_o;
      en    = tdo_en_o;
      @(posedge tck_i);
      @(negedge tck_i);
      #1;
   endtask

   task automatic go_rti();
      logic t, e;
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
   endtask

   task automatic ir_scan(input logic [3:0] val, output logic [3:0] dout,
                          output logic [3:0] en, output logic en_pre, output logic en_post);
      logic t, e;
      tick(1'b1, 1'b0, t, e);
      tick(1'b1, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
      tick(1'b0, 1'b0, t, en_pre);
      for (int i = 0; i < 4; i++) tick(i == 3, val[i], dout[i], en[i]);
      tick(1'b1, 1'b0, t, en_post);
      tick(1'b0, 1'b0, t, e);
   endtask

   task automatic dr_scan(input int n, input logic [39:0] din, output logic [39:0] dout);
      logic t, e;
      dout = '0;
      tick(1'b1, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
      for (int i = 0; i < n; i++) tick(i == n - 1, din[i], dout[i], e);
      tick(1'b1, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
   endtask

   task automatic test_reset();
      tests++; if (tap_rst_o !== 1'b1) begin fails++; $display("FAIL reset_tap_rst got %b exp 1", tap_rst_o); end
      tests++; if (clksel_o !== 1'b1) begin fails++; $display("FAIL reset_clksel got %b exp 1", clksel_o); end
      tests++; if (tdo_o !== 1'b0) begin fails++; $display("FAIL reset_tdo got %b exp 0", tdo_o); end
      tests++; if (tdo_en_o !== 1'b0) begin fails++; $display("FAIL reset_tdo_en got %b exp 0", tdo_en_o); end
      tests++; if (dut.ir_q !== 4'h1) begin fails++; $display("FAIL reset_ir got %h exp 1", dut.ir_q); end
   endtask

   task automatic test_state_walk();
      logic [7:0] seq;
      int         len;
      logic       t, e;
      logic [3:0] d, en;
      logic       p0, p1;
      tap_state_e s;
      for (int k = 0; k < 16; k++) begin
         s = tap_state_e'(k);
         case (s)
            RTI:    begin seq = 8'b0;        len = 0; end
            SEL_DR: begin seq = 8'b1;        len = 1; end
            CAP_DR: begin seq = 8'b01;       len = 2; end
            SH_DR:  begin seq = 8'b001;      len = 3; end
            EX1_DR: begin seq = 8'b101;      len = 3; end
            PAU_DR: begin seq = 8'b0101;     len = 4; end
            EX2_DR: begin seq = 8'b10101;    len = 5; end
            UPD_DR: begin seq = 8'b1101;     len = 4; end
            SEL_IR: begin seq = 8'b11;       len = 2; end
            CAP_IR: begin seq = 8'b011;      len = 3; end
            SH_IR:  begin seq = 8'b0011;     len = 4; end
            EX1_IR: begin seq = 8'b1011;     len = 4; end
            PAU_IR: begin seq = 8'b01011;    len = 5; end
            EX2_IR: begin seq = 8'b101011;   len = 6; end
            UPD_IR: begin seq = 8'b11011;    len = 5; end
            default: begin seq = 8'b111;     len = 3; end
         endcase
         go_rti();
         ir_scan(4'hF, d, en, p0, p1);
         for (int i = 0; i < len; i++) tick(seq[i], 1'b0, t, e);
         tests++;
         if (dut.u_fsm.state_o !== s) begin
            fails++; $display("FAIL walk_reach[%0d] got %0d exp %0d", k, dut.u_fsm.state_o, s);
         end
         for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t, e);
         tests++; if (tap_rst_o !== 1'b1) begin fails++; $display("FAIL walk_tlr[%0d] tap_rst got %b exp 1", k, tap_rst_o); end
         tests++; if (dut.ir_q !== 4'h1) begin fails++; $display("FAIL walk_ir[%0d] got %h exp 1", k, dut.ir_q); end
      end
   endtask

   task automatic test_ir_scan();
      logic [3:0] d, en;
      logic       p0, p1;
      go_rti();
      ir_scan(4'hF, d, en, p0, p1);
      tests++; if (d !== 4'b0101) begin fails++; $display("FAIL ir_tdo got %b exp 0101", d); end
      tests++; if (en !== 4'hF) begin fails++; $display("FAIL ir_en_shift got %b exp 1111", en); end
      tests++; if ({p0, p1} !== 2'b00) begin fails++; $display("FAIL ir_en_edges got %b exp 00", {p0, p1}); end
      tests++; if (dut.ir_q !== 4'hF) begin fails++; $display("FAIL ir_update got %h exp f", dut.ir_q); end
   endtask

   task automatic test_idcode();
      logic [39:0] q;
      go_rti();
      dr_scan(32, 40'h0, q);
      tests++; if (q[31:0] !== 32'h1000_0001) begin fails++; $display("FAIL idcode got %h exp 10000001", q[31:0]); end
      tests++; if ({tdo_o, tdo_en_o} !== 2'b00) begin fails++; $display("FAIL idle_tdo got %b exp 00", {tdo_o, tdo_en_o}); end
      dr_scan(36, 40'hA, q);
      tests++; if (q[35:0] !== 36'hA_1000_0001) begin fails++; $display("FAIL idcode_overshift got %h exp a10000001", q[35:0]); end
   endtask

   task automatic test_clksel();
      logic [3:0]  d, en;
      logic        p0, p1, t, e;
      logic [39:0] q;
      go_rti();
      ir_scan(4'h8, d, en, p0, p1);
      tests++; if (clksel_o !== 1'b1) begin fails++; $display("FAIL csel_pre got %b exp 1", clksel_o); end
      dr_scan(1, 40'h0, q);
      tests++; if (q[0] !== 1'b1) begin fails++; $display("FAIL csel_cap1 got %b exp 1", q[0]); end
      tests++; if (clksel_o !== 1'b0) begin fails++; $display("FAIL csel_upd got %b exp 0", clksel_o); end
      dr_scan(1, 40'h0, q);
      tests++; if (q[0] !== 1'b0) begin fails++; $display("FAIL csel_cap0 got %b exp 0", q[0]); end
      // Shift a 1 then park in Pause-DR: no commit without Update-DR.
      tick(1'b1, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
      tick(1'b1, 1'b1, t, e);
      tick(1'b0, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
      tests++; if (clksel_o !== 1'b0) begin fails++; $display("FAIL csel_pause got %b exp 0", clksel_o); end
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t, e);
      tests++; if (clksel_o !== 1'b1) begin fails++; $display("FAIL csel_tlr got %b exp 1", clksel_o); end
   endtask

   task automatic test_bypass();
      logic [3:0]  d, en;
      logic        p0, p1;
      logic [39:0] q;
      go_rti();
      ir_scan(4'h3, d, en, p0, p1);
      dr_scan(3, 40'b011, q);
      tests++; if (q[2:0] !== 3'b110) begin fails++; $display("FAIL bypass got %b exp 110", q[2:0]); end
   endtask

   task automatic test_reset_mid_shift();
      logic [3:0] d, en;
      logic       p0, p1, t, e;
      go_rti();
      ir_scan(4'h8, d, en, p0, p1);
      tick(1'b1, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
      tick(1'b0, 1'b0, t, e);
      tests++; if (tdo_en_o !== 1'b1) begin fails++; $display("FAIL rst_mid_inshift got %b exp 1", tdo_en_o); end
      tms_i = 1'b1;
      #1 trst_ni = 1'b0;
      #1;
      tests++; if (clksel_o !== 1'b1) begin fails++; $display("FAIL rst_mid_clksel got %b exp 1", clksel_o); end
      tests++; if (tap_rst_o !== 1'b1) begin fails++; $display("FAIL rst_mid_tlr got %b exp 1", tap_rst_o); end
      tests++; if (tdo_en_o !== 1'b0) begin fails++; $display("FAIL rst_mid_en got %b exp 0", tdo_en_o); end
      trst_ni = 1'b1;
      @(negedge tck_i);
      #1;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, t, e);
      tests++; if ({clksel_o, dut.ir_q} !== 5'b1_0001) begin fails++; $display("FAIL rst_mid_after got %b exp 10001", {clksel_o, dut.ir_q}); end
   endtask

   initial begin
      #12;
      test_reset();
      trst_ni = 1'b1;
      test_state_walk();
      test_ir_scan();
      test_idcode();
      test_clksel();
      test_bypass();
      test_reset_mid_shift();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
